// File: rtl/circular_counter_32bit.sv
// Modulo-2^WIDTH phase accumulator feeding the sine generator's phase input.
// Emits a one-cycle wrap strobe on each overflow and exports the top phase bits.
module circular_counter_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned QBITS = 2
) (
  input  logic             CLK,
  input  logic             SCLR,
  input  logic [WIDTH-1:0] increment_value,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap,
  output logic [QBITS-1:0] quadrant
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, count_out} + {1'b0, increment_value};
  end

  // Carry out of the WIDTH+1-bit sum becomes the registered wrap strobe.
  always_ff @(posedge CLK or posedge SCLR) begin
    if (SCLR) begin
      count_out <= '0;
      wrap      <= 1'b0;
    end else begin
      count_out <= sum[WIDTH-1:0];
      wrap      <= sum[WIDTH];
    end
  end

  assign quadrant = count_out[WIDTH-1 -: QBITS];

endmodule

// File: tb/tb_circular_counter_32bit.sv
// Directed self-checking bench for circular_counter_32bit with default parameters.
module tb_circular_counter_32bit;

  logic        CLK;
  logic        SCLR;
  logic [31:0] increment_value;
  logic [31:0] count_out;
  logic        wrap;
  logic [1:0]  quadrant;

  int checks   = 0;
  int failures = 0;

  circular_counter_32bit #(.WIDTH(32), .QBITS(2)) dut (
    .CLK             (CLK),
    .SCLR            (SCLR),
    .increment_value (increment_value),
    .count_out       (count_out),
    .wrap            (wrap),
    .quadrant        (quadrant)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    SCLR = 1'b1;
    tick();
    SCLR = 1'b0;
  endtask

  task automatic test_reset();
    SCLR = 1'b1;
    increment_value = 'x;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (count_out !== 32'd0 || wrap !== 1'b0 || quadrant !== 2'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: count=%h wrap=%b quad=%0d, required 0/0/0",
                 i, count_out, wrap, quadrant);
      end
      tick();
    end
    increment_value = 32'd4000;
    tick();
    checks++;
    if (count_out !== 32'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_edge_with_step: count=%h wrap=%b, required 0/0", count_out, wrap);
    end
    SCLR = 1'b0;
  endtask

  task automatic test_basic_ramp();
    logic [31:0] exp;
    increment_value = 32'd4000;
    for (int n = 1; n <= 5; n++) begin
      tick();
      exp = 32'd4000 * n;
      checks++;
      if (count_out !== exp || wrap !== 1'b0 || quadrant !== 2'd0) begin
        failures++;
        $display("FAIL ramp[%0d]: count=%0d wrap=%b quad=%0d, required %0d/0/0",
                 n, count_out, wrap, quadrant, exp);
      end
    end
  endtask

  task automatic test_wrap_around();
    // Shortcut for 1,073,741 steps of 4000, then the final step lands on 704.
    apply_reset();
    increment_value = 32'd4000;
    tick(); tick(); tick();
    increment_value = 32'd4294952000;
    tick();
    checks++;
    if (count_out !== 32'd4294964000 || wrap !== 1'b0 || quadrant !== 2'd3) begin
      failures++;
      $display("FAIL wrap_pre: count=%0d wrap=%b quad=%0d, required 4294964000/0/3",
               count_out, wrap, quadrant);
    end
    increment_value = 32'd4000;
    tick();
    checks++;
    if (count_out !== 32'd704 || wrap !== 1'b1 || quadrant !== 2'd0) begin
      failures++;
      $display("FAIL wrap_land: count=%0d wrap=%b quad=%0d, required 704/1/0",
               count_out, wrap, quadrant);
    end
    tick();
    checks++;
    if (count_out !== 32'd4704 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_single_pulse: count=%0d wrap=%b, required 4704/0", count_out, wrap);
    end
  endtask

  task automatic test_quadrants();
    logic [1:0]  exp_q [4];
    logic        exp_w [4];
    logic [31:0] exp_c [4];
    exp_c = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    increment_value = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count_out !== exp_c[i] || quadrant !== exp_q[i] || wrap !== exp_w[i]) begin
        failures++;
        $display("FAIL quadrant[%0d]: count=%h quad=%0d wrap=%b, required %h/%0d/%b",
                 i, count_out, quadrant, wrap, exp_c[i], exp_q[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_step_change();
    logic [31:0] exp;
    apply_reset();
    increment_value = 32'd4000;
    tick(); tick();
    increment_value = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count_out !== 32'd8000 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL zero_step[%0d]: count=%0d wrap=%b, required 8000/0", i, count_out, wrap);
      end
    end
    increment_value = 32'd1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = 32'd8000 + i;
      checks++;
      if (count_out !== exp || wrap !== 1'b0) begin
        failures++;
        $display("FAIL unit_step[%0d]: count=%0d wrap=%b, required %0d/0", i, count_out, wrap, exp);
      end
    end
  endtask

  task automatic test_decrement();
    apply_reset();
    increment_value = 32'd1;
    tick();
    increment_value = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (count_out !== 32'd0 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL dec_to_zero: count=%h wrap=%b, required 00000000/1", count_out, wrap);
    end
    tick();
    checks++;
    if (count_out !== 32'hFFFF_FFFF || wrap !== 1'b0 || quadrant !== 2'd3) begin
      failures++;
      $display("FAIL dec_from_zero: count=%h wrap=%b quad=%0d, required ffffffff/0/3",
               count_out, wrap, quadrant);
    end
    tick();
    checks++;
    if (count_out !== 32'hFFFF_FFFE || wrap !== 1'b1) begin
      failures++;
      $display("FAIL dec_again: count=%h wrap=%b, required fffffffe/1", count_out, wrap);
    end
  endtask

  task automatic test_exact_landing();
    apply_reset();
    increment_value = 32'hFFFF_F000;
    tick();
    increment_value = 32'h0000_1000;
    tick();
    checks++;
    if (count_out !== 32'd0 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL exact_landing: count=%h wrap=%b, required 00000000/1", count_out, wrap);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp;
    apply_reset();
    increment_value = 32'h8000_0000;
    tick();
    increment_value = 32'h9234_5678;
    tick();
    checks++;
    if (count_out !== 32'h1234_5678 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL async_preload: count=%h wrap=%b, required 12345678/1", count_out, wrap);
    end
    increment_value = 32'd4000;
    #3;
    SCLR = 1'b1;
    #1;
    checks++;
    if (count_out !== 32'd0 || wrap !== 1'b0 || quadrant !== 2'd0) begin
      failures++;
      $display("FAIL async_clear: count=%h wrap=%b quad=%0d, required 0/0/0",
               count_out, wrap, quadrant);
    end
    tick();
    checks++;
    if (count_out !== 32'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_hold: count=%h wrap=%b, required 0/0", count_out, wrap);
    end
    SCLR = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      tick();
      exp = 32'd4000 * n;
      checks++;
      if (count_out !== exp || wrap !== 1'b0) begin
        failures++;
        $display("FAIL async_resume[%0d]: count=%0d wrap=%b, required %0d/0",
                 n, count_out, wrap, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ramp();
    test_wrap_around();
    test_quadrants();
    test_step_change();
    test_decrement();
    test_exact_landing();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circular_counter_32bit.md
Name: circular_counter_32bit

Overview:
- 32-bit modulo-2^32 phase accumulator, the "circular counter" that drives the phase input of the sine-wave generator.
- Every clock, the programmable step `increment_value` is added to the running count, and the sum wraps silently.
- The upper phase bits feed the sine lookup downstream.
- A wrap pulse marks each completed cycle, for use as a cycle strobe.

Parameters:
- WIDTH, 32: accumulator, increment and output width in bits.
- QBITS, 2: number of MSBs exported on `quadrant`. Must be 1..WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- SCLR  input  1  asynchronous, active-high reset; clears all state immediately.
- increment_value  input  WIDTH  phase step added every clock; unsigned.
- count_out  output  WIDTH  registered accumulator value.
- wrap  output  1  registered one-cycle pulse, high in the cycle after an addition overflows.
- quadrant  output  QBITS  equals count_out[WIDTH-1 -: QBITS]; purely combinational from count_out.

Behaviour:
- Clock and reset:
  - One clock domain (CLK).
  - SCLR is asynchronous and active-high.
  - While SCLR=1: count_out=0, wrap=0, quadrant=0, regardless of the clock and of increment_value (X or otherwise).
  - SCLR is asserted asynchronously and released synchronously by design use; deassertion must meet recovery/removal at CLK.
- Accumulate (SCLR=0), at each rising CLK edge:
  - {carry, next} = {1'b0, count_out} + {1'b0, increment_value}, computed in WIDTH+1 bits.
  - count_out <= next (the lower WIDTH bits), so arithmetic is modulo 2^WIDTH.
  - wrap <= carry.
- Latency:
  - increment_value is sampled at the rising edge and is not registered separately.
  - A change takes effect on the count at the first edge at which the new value is present, i.e. one cycle of latency from input to count_out.
- Boundaries:
  - increment_value = 0: count_out holds its value and wrap stays 0.
  - increment_value = 2^WIDTH-1: the count decrements by 1 per clock (modulo). wrap=1 on every edge except when count_out was 0 before the edge.
  - Exact landing on 0 (e.g. 0xFFFFF000 + 0x1000): count_out=0 and wrap=1.
  - wrap never stays high for two consecutive cycles unless overflow occurs on consecutive edges (possible when increment ≥ 2^(WIDTH-1)).
- Simultaneous events:
  - A rising edge coinciding with SCLR=1 leaves the outputs at reset values.
  - The first accumulation occurs at the first rising edge that samples SCLR=0.
- Reset mid-operation: asserting SCLR clears count_out and wrap immediately, with no clock needed. On release, accumulation restarts from 0 with the current increment_value.
- No saturation, no enable and no other state. The design is fully synchronous apart from the asynchronous clear.

Test Plan:
- Reset and hold:
  - Stimulus: SCLR=1, increment_value=X, 10 ns clock (CLK starts 1).
  - Required: count_out=0, wrap=0, quadrant=0 throughout.
- Basic ramp:
  - Stimulus: at t=10 ns, SCLR->0 and increment_value=4000.
  - Required: after N accumulating edges, count_out = 4000*N. So 4000, 8000, 12000… and wrap=0.
- Wrap-around:
  - Stimulus: increment_value=4000 held from 0 for 1,073,742 edges.
  - Required: count_out = 704 after the last edge, with a single wrap pulse in that cycle. quadrant goes 0→1→2→3→0 across the run.
- Step change and zero step:
  - Stimulus: from count_out=8000, set increment_value=0 for 5 edges, then 1.
  - Required: count_out stays 8000 for those 5 edges, then 8001, 8002, …
- Decrement and exact zero:
  - Stimulus: load to 0x00000001, then apply increment_value=0xFFFFFFFF.
  - Required:
    - first edge: count_out=0, wrap=1.
    - next edge: count_out=0xFFFFFFFF, wrap=0.
- Asynchronous reset mid-run:
  - Stimulus: assert SCLR between clock edges while count_out=0x12345678.
  - Required: count_out and wrap clear to 0 before the next edge. After release, counting resumes 4000, 8000, …
